// File: rtl/count_sched.sv
// count_sched: round-robin scheduler that shares one up/down counter among
// NREQ requesters. Each granted requester has the counter walked along the
// shortest modular path to its latched target, then receives a done pulse.
//
// Optional watchdog: define COUNT_SCHED_WATCHDOG_EN to abort a move that
// lasts TO_CYCLES MOVE cycles without reaching the target (err pulse).
//
// Ports:
//   clk      clock, all logic on posedge
//   rst      synchronous reset, active-high
//   req      per-requester request level, held until done or withdraw
//   tgt      per-requester targets, requester i at [i*WIDTH +: WIDTH]
//   cnt_q    current value of the shared counter
//   cnt_en   counter step enable (combinational)
//   cnt_dir  counter step direction, 1 = up
//   gnt      registered one-hot grant
//   done     registered one-cycle completion pulse
//   busy     high whenever the scheduler is not idle
//   err      one-cycle watchdog abort pulse (0 without the watchdog)
module count_sched #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 4,
  parameter int TO_CYCLES = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0]      cnt_q,
  output logic                  cnt_en,
  output logic                  cnt_dir,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Half of the modular range; a tie at exactly this distance goes up.
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     pick;
  logic [WIDTH-1:0]  tgt_l, tgt_sel, diff;
  logic [NREQ-1:0]   gnt_n, done_n;
  logic              load, req_win, timeout;

  // Round-robin pick: lowest requester above the pointer wins; if none,
  // wrap around to the lowest requester at or below the pointer.
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i] && i <= int'(ptr)) pick = IW'(i);
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i] && i > int'(ptr)) pick = IW'(i);
  end

  always_comb begin
    tgt_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (IW'(i) == pick) tgt_sel = tgt[i*WIDTH +: WIDTH];
  end

  assign diff    = tgt_l - cnt_q;
  // gnt is one-hot in MOVE, so this is the granted requester's req bit.
  assign req_win = |(req & gnt);
  assign busy    = (state != IDLE);

`ifdef COUNT_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TO_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TO_CYCLES - 1);

  logic [WDW-1:0] wd;
  logic           err_q;

  // wd counts MOVE cycles already elapsed; it is zero on the first MOVE cycle.
  always_ff @(posedge clk) begin
    if (rst || state != MOVE) wd <= '0;
    else                      wd <= wd + 1'b1;
  end

  assign timeout = (wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == MOVE) && req_win && (diff != '0) && timeout;
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = '0;
    ptr_n   = ptr;
    load    = 1'b0;
    cnt_en  = 1'b0;
    cnt_dir = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = MOVE;
          gnt_n   = NREQ'(1) << pick;
          ptr_n   = pick;
          load    = 1'b1;
        end
      end
      MOVE: begin
        cnt_dir = (diff <= HALF);
        // Withdraw beats arrival, arrival beats the watchdog.
        if (!req_win) begin
          state_n = IDLE;
          gnt_n   = '0;
        end else if (diff == '0) begin
          state_n = DONE;
          gnt_n   = '0;
          done_n  = gnt;
        end else begin
          cnt_en = 1'b1;
          if (timeout) begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      ptr   <= IW'(NREQ - 1);
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      ptr   <= ptr_n;
    end
  end

  // Target latch carries data only; it is meaningful solely while granted.
  always_ff @(posedge clk) begin
    if (load) tgt_l <= tgt_sel;
  end

endmodule
